regfile_dump: RTL and testbench
===============================

REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of registers scanned (1..32).
REQ-002 SHALL have parameter DW, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request a full dump, sampled only in IDLE.
REQ-006 SHALL have port rf_addr  output  5  read address to register-file read port (combinational read).
REQ-007 SHALL have port rf_rdata  input  DW  register-file read data for rf_addr.
REQ-008 SHALL have port out_valid  output  1  out_index/out_data valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts word when high with out_valid.
REQ-010 SHALL have port out_index  output  6  register index of current word (NREGS for checksum word).
REQ-011 SHALL have port out_data  output  DW  dumped word.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement FSM states IDLE, READ, SEND, CSUM, DONE.
REQ-015 SHALL move IDLE->READ on start=1, clearing index counter to 0 and checksum to 0.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL drive rf_addr = index in READ and rf_addr = 0 in all other states.
REQ-018 SHALL, in READ, capture rf_rdata into out_data register and move to SEND next edge (one cycle read latency).
REQ-019 SHALL assert out_valid only in SEND and CSUM, registered, with out_index/out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL complete a transfer only on a clock edge where out_valid=1 and out_ready=1.
REQ-021 SHALL, on SEND transfer with index < NREGS-1, increment index and return to READ (minimum 2 cycles per word).
REQ-022 SHALL, on SEND transfer with index = NREGS-1, go to CSUM if enabled (REQ-030) else DONE.
REQ-023 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-024 SHALL never write the register file; block is read-only.
REQ-025 SHALL not wrap the index past NREGS-1; index width 6 bits, no overflow possible.
REQ-026 SHALL accept out_ready=1 while out_valid=0 without effect.

Reset
REQ-027 SHALL, on reset_n=0 at any time including mid-dump, immediately enter IDLE with index=0, checksum=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0, rf_addr=0.
REQ-028 SHALL resume operation on the first rising clk edge after reset_n deasserts, requiring a fresh start.

Configuration
REQ-029 SHALL use macro REGFILE_DUMP_CHECKSUM_EN to include/exclude the checksum word.
REQ-030 SHALL, with REGFILE_DUMP_CHECKSUM_EN defined, XOR every transferred word into a DW-bit checksum and, in CSUM, present out_index=NREGS, out_data=checksum with out_valid=1; on transfer go to DONE.
REQ-031 SHALL, without REGFILE_DUMP_CHECKSUM_EN, omit CSUM state and checksum register; dump is exactly NREGS words.

Verification
REQ-032 SHALL cover: regfile preloaded x1=0x11,x2=0x22, others 0, out_ready=1, start pulse -> 32 words, index 0..31, x0 data 0, x1 0x11, x2 0x22, done pulse once, 64 cycles start-to-last-transfer.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles during index 3 -> out_valid stays 1, out_index=3 and out_data unchanged, no index advance.
REQ-034 SHALL cover: with REGFILE_DUMP_CHECKSUM_EN, regs x1=0xA5A5A5A5, x2=0x0F0F0F0F, others 0 -> 33rd word out_index=32, out_data=0xAAAAAAAA.
REQ-035 SHALL cover: start pulsed again at index 10 -> ignored, dump continues, single done pulse.
REQ-036 SHALL cover: reset_n pulled low at index 7 with out_valid=1 -> all outputs 0 asynchronously, next start restarts at index 0.
REQ-037 SHALL cover: NREGS=4 build -> indices 0..3 only, rf_addr never exceeds 3.

Source files
------------

// File: rtl/regfile_dump.sv
// regfile_dump: scans register-file entries 0..NREGS-1 through a combinational read port
//   and streams each one out over a valid/ready handshake.
// Latency: 1 cycle from start to the first read; at least 2 cycles per word (READ then SEND).
// Backpressure: out_valid is held and out_index/out_data stay stable while out_ready=0.
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word.
//   That word carries out_index=NREGS and out_data=XOR of all words sent.
// Ports:
//   clk, reset_n          - clock (rising edge) and asynchronous active-low reset
//   start                 - request a full dump; only looked at while idle
//   rf_addr / rf_rdata    - register-file read port (address out, data back in the same cycle)
//   out_valid/out_ready   - output handshake; a word moves on an edge where both are high
//   out_index / out_data  - register index (NREGS for the checksum) and its data
//   busy / done           - busy while not idle; done pulses for one cycle at the end
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic [4:0]    rf_addr,
  input  logic [DW-1:0] rf_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_index,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam logic [5:0] LAST_IDX = 6'(NREGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [5:0] CSUM_IDX = 6'(NREGS);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;
`endif

  state_t          r_state;
  state_t          w_next_state;
  logic [5:0]      r_index;
  logic [DW-1:0]   r_out_data;
  logic            w_xfer;
  logic            w_last;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DW-1:0]   r_csum;
`endif

  assign w_xfer = out_valid & out_ready;
  assign w_last = (r_index == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs. All outputs are decoded from registers only.
  always_comb begin
    w_next_state = r_state;
    rf_addr      = '0;
    out_valid    = 1'b0;
    out_index    = '0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_READ;
      end
      S_READ: begin
        rf_addr      = r_index[4:0];
        w_next_state = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_index = r_index;
        if (w_xfer) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          w_next_state = w_last ? S_CSUM : S_READ;
`else
          w_next_state = w_last ? S_DONE : S_READ;
`endif
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_valid = 1'b1;
        out_index = CSUM_IDX;
        if (w_xfer) w_next_state = S_DONE;
      end
`endif
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign out_data = r_out_data;

  // Datapath: index counter, captured read data and running checksum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index    <= '0;
      r_out_data <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_index <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_READ: begin
          r_out_data <= rf_rdata;
        end
        S_SEND: begin
          if (w_xfer) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum <= r_csum ^ r_out_data;
            // The last word is folded in directly so the checksum word is ready next cycle.
            if (w_last) r_out_data <= r_csum ^ r_out_data;
`endif
            // Index stops at NREGS-1; it never wraps.
            if (!w_last) r_index <= r_index + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        clk;
  logic        reset_n;
  logic        start, start4;
  logic        out_ready, out_ready4;
  logic [4:0]  rf_addr, rf_addr4;
  logic [31:0] rf_rdata, rf_rdata4;
  logic        out_valid, out_valid4;
  logic [5:0]  out_index, out_index4;
  logic [31:0] out_data, out_data4;
  logic        busy, busy4, done, done4;

  logic [31:0] rf [32];
  assign rf_rdata  = rf[rf_addr];
  assign rf_rdata4 = rf[rf_addr4];

  regfile_dump #(.NREGS(32), .DW(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done)
  );

  regfile_dump #(.NREGS(4), .DW(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4),
    .rf_addr(rf_addr4), .rf_rdata(rf_rdata4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_index(out_index4), .out_data(out_data4),
    .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CSUM_WORDS = 1;
`else
  localparam int CSUM_WORDS = 0;
`endif

  int checks = 0;
  int failures = 0;

  int          cap_idx [$];
  logic [31:0] cap_dat [$];
  int          done_cnt;
  int          last_cyc;
  bit          finished;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    int          stall_at;
    int          restart_at;
    int          exp_last_cyc;
    logic [31:0] exp_csum;
  } row_t;

  row_t rows [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] x1, input logic [31:0] x2);
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = x1;
    rf[2] = x2;
  endtask

  // Runs one dump on the 32-entry DUT. n counts negedges since start; the posedge
  // following negedge n is edge n, with the start sampled on edge 0.
  task automatic run_dump(input int stall_at, input int restart_at);
    int          n;
    bit          stalled;
    logic [31:0] hold;
    cap_idx.delete();
    cap_dat.delete();
    done_cnt = 0;
    last_cyc = -1;
    finished = 0;
    stalled  = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) done_cnt++;
      if (!busy) begin
        finished = 1;
        break;
      end
      if (restart_at >= 0 && out_valid && out_index == 6'(restart_at)) start = 1'b1;
      if (stall_at >= 0 && !stalled && out_valid && out_index == 6'(stall_at)) begin
        stalled = 1;
        out_ready = 1'b0;
        hold = out_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n++;
          chk($sformatf("stall_valid[%0d]", k), {63'd0, out_valid}, 64'd1);
          chk($sformatf("stall_index[%0d]", k), {58'd0, out_index}, 64'(stall_at));
          chk($sformatf("stall_data[%0d]", k), {32'd0, out_data}, {32'd0, hold});
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        cap_idx.push_back(int'(out_index));
        cap_dat.push_back(out_data);
        if (out_index == 6'd31) last_cyc = n;
      end
    end
  endtask

  task automatic check_row(input int r, input row_t rw);
    logic [31:0] exp_d;
    chk($sformatf("r%0d_finished", r), {63'd0, finished}, 64'd1);
    chk($sformatf("r%0d_word_count", r), 64'(cap_idx.size()), 64'(32 + CSUM_WORDS));
    chk($sformatf("r%0d_done_pulses", r), 64'(done_cnt), 64'd1);
    chk($sformatf("r%0d_last_cycle", r), 64'(last_cyc), 64'(rw.exp_last_cyc));
    for (int i = 0; i < 32 && i < cap_idx.size(); i++) begin
      exp_d = (i == 1) ? rw.x1 : (i == 2) ? rw.x2 : 32'h0;
      chk($sformatf("r%0d_idx[%0d]", r, i), 64'(cap_idx[i]), 64'(i));
      chk($sformatf("r%0d_dat[%0d]", r, i), {32'd0, cap_dat[i]}, {32'd0, exp_d});
    end
    if (CSUM_WORDS == 1 && cap_idx.size() > 32) begin
      chk($sformatf("r%0d_csum_idx", r), 64'(cap_idx[32]), 64'd32);
      chk($sformatf("r%0d_csum_dat", r), {32'd0, cap_dat[32]}, {32'd0, rw.exp_csum});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_index"}, {58'd0, out_index}, 64'd0);
    chk({tag, "_out_data"},  {32'd0, out_data},  64'd0);
    chk({tag, "_busy"},      {63'd0, busy},      64'd0);
    chk({tag, "_done"},      {63'd0, done},      64'd0);
    chk({tag, "_rf_addr"},   {59'd0, rf_addr},   64'd0);
  endtask

  initial begin
    int          n;
    bit          hit;
    int          addr_viol;
    int          d4;
    int          idx4 [$];
    logic [31:0] dat4 [$];

    rows[0] = '{x1: 32'h11, x2: 32'h22, stall_at: -1, restart_at: -1,
                exp_last_cyc: 64, exp_csum: 32'h33};
    rows[1] = '{x1: 32'h11, x2: 32'h22, stall_at: 3, restart_at: -1,
                exp_last_cyc: 69, exp_csum: 32'h33};
    rows[2] = '{x1: 32'hA5A5A5A5, x2: 32'h0F0F0F0F, stall_at: -1, restart_at: 10,
                exp_last_cyc: 64, exp_csum: 32'hAAAAAAAA};

    reset_n = 1'b0;
    start = 1'b0; start4 = 1'b0;
    out_ready = 1'b0; out_ready4 = 1'b0;
    preload(32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_busy4", {63'd0, busy4}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (rows[r]) begin
      preload(rows[r].x1, rows[r].x2);
      run_dump(rows[r].stall_at, rows[r].restart_at);
      check_row(r, rows[r]);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a dump while index 7 is being offered.
    preload(rows[0].x1, rows[0].x2);
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (n = 0; n < 100; n++) begin
      if (out_valid && out_index == 6'd7) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midreset_reached_idx7", {63'd0, hit}, 64'd1);
    #1 reset_n = 1'b0;
    #1 check_idle_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_busy", {63'd0, busy}, 64'd0);
    chk("post_reset_idle_valid", {63'd0, out_valid}, 64'd0);
    run_dump(-1, -1);
    check_row(3, rows[0]);

    // Four-register instance.
    preload(32'hA5A5A5A5, 32'h0F0F0F0F);
    @(negedge clk);
    start4 = 1'b1;
    out_ready4 = 1'b1;
    addr_viol = 0;
    d4 = 0;
    hit = 0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (rf_addr4 > 5'd3) addr_viol++;
      if (done4) d4++;
      if (!busy4) begin
        hit = 1;
        break;
      end
      if (out_valid4 && out_ready4) begin
        idx4.push_back(int'(out_index4));
        dat4.push_back(out_data4);
      end
    end
    chk("n4_finished", {63'd0, hit}, 64'd1);
    chk("n4_rf_addr_over_3", 64'(addr_viol), 64'd0);
    chk("n4_done_pulses", 64'(d4), 64'd1);
    chk("n4_word_count", 64'(idx4.size()), 64'(4 + CSUM_WORDS));
    for (int i = 0; i < 4 && i < idx4.size(); i++) begin
      chk($sformatf("n4_idx[%0d]", i), 64'(idx4[i]), 64'(i));
      chk($sformatf("n4_dat[%0d]", i), {32'd0, dat4[i]},
          (i == 1) ? 64'hA5A5A5A5 : (i == 2) ? 64'h0F0F0F0F : 64'h0);
    end
    if (CSUM_WORDS == 1 && idx4.size() > 4) begin
      chk("n4_csum_idx", 64'(idx4[4]), 64'd4);
      chk("n4_csum_dat", {32'd0, dat4[4]}, 64'hAAAAAAAA);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
